// File: rtl/snn_run_ctrl.sv
// Run sequencer: per-layer load request, then one step per timestep, then a run_done pulse.
// Optional watchdog on the wait states is enabled by defining SNN_CTRL_TIMEOUT_EN.
module snn_run_ctrl #(
    parameter int unsigned TS_W           = 4,
    parameter int unsigned LAYER_W        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [TS_W-1:0]    cfg_num_ts,
    input  logic [LAYER_W-1:0] cfg_num_layers,
    output logic               load_start_valid,
    input  logic               load_start_ready,
    output logic [LAYER_W-1:0] load_layer,
    input  logic               load_done,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [TS_W-1:0]    step_ts,
    output logic [LAYER_W-1:0] step_layer,
    input  logic               step_done,
    output logic               busy,
    output logic               run_done,
    output logic               err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadReq,
        StLoadWait,
        StStepReq,
        StStepWait,
        StFinish
    } state_e;

    state_e state_q, state_d;

    logic [TS_W-1:0]    num_ts_q, num_ts_d;
    logic [LAYER_W-1:0] num_layers_q, num_layers_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               err_q, err_d;

    logic               load_start_valid_q, load_start_valid_d;
    logic [LAYER_W-1:0] load_layer_q, load_layer_d;
    logic               step_valid_q, step_valid_d;
    logic [TS_W-1:0]    step_ts_q, step_ts_d;
    logic [LAYER_W-1:0] step_layer_q, step_layer_d;
    logic               run_done_q, run_done_d;

    logic               timeout_hit;
    logic               last_ts;
    logic               last_layer;

    assign last_ts    = (ts_q == (num_ts_q - TS_W'(1)));
    assign last_layer = (layer_q == (num_layers_q - LAYER_W'(1)));

`ifdef SNN_CTRL_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             in_wait;

    assign in_wait     = (state_q == StLoadWait) || (state_q == StStepWait);
    assign timeout_hit = in_wait && (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));

    // Restarts from zero on every entry into a wait state, counts while staying there.
    always_comb begin
        wdog_d = '0;
        if (in_wait && (state_d == state_q)) begin
            wdog_d = wdog_q + WdogW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // State and run-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            num_ts_q     <= TS_W'(1);
            num_layers_q <= LAYER_W'(1);
            ts_q         <= '0;
            layer_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_ts_q     <= num_ts_d;
            num_layers_q <= num_layers_d;
            ts_q         <= ts_d;
            layer_q      <= layer_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_ts_d     = num_ts_q;
        num_layers_d = num_layers_q;
        ts_d         = ts_q;
        layer_d      = layer_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    num_ts_d     = (cfg_num_ts == '0) ? TS_W'(1) : cfg_num_ts;
                    num_layers_d = (cfg_num_layers == '0) ? LAYER_W'(1) : cfg_num_layers;
                    ts_d         = '0;
                    layer_d      = '0;
                    err_d        = 1'b0;
                    state_d      = StLoadReq;
                end
            end
            StLoadReq: begin
                if (load_start_ready) begin
                    state_d = StLoadWait;
                end
            end
            StLoadWait: begin
                // A done pulse on the limit cycle takes priority over the timeout.
                if (load_done) begin
                    ts_d    = '0;
                    state_d = StStepReq;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StStepReq: begin
                if (step_ready) begin
                    state_d = StStepWait;
                end
            end
            StStepWait: begin
                if (step_done) begin
                    if (!last_ts) begin
                        ts_d    = ts_q + TS_W'(1);
                        state_d = StStepReq;
                    end else if (!last_layer) begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = StLoadReq;
                    end else begin
                        state_d = StFinish;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with the state change.
    always_comb begin
        load_start_valid_d = (state_d == StLoadReq);
        load_layer_d       = layer_d;
        step_valid_d       = (state_d == StStepReq);
        step_ts_d          = ts_d;
        step_layer_d       = layer_d;
        run_done_d         = (state_d == StFinish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_start_valid_q <= 1'b0;
            load_layer_q       <= '0;
            step_valid_q       <= 1'b0;
            step_ts_q          <= '0;
            step_layer_q       <= '0;
            run_done_q         <= 1'b0;
        end else begin
            load_start_valid_q <= load_start_valid_d;
            load_layer_q       <= load_layer_d;
            step_valid_q       <= step_valid_d;
            step_ts_q          <= step_ts_d;
            step_layer_q       <= step_layer_d;
            run_done_q         <= run_done_d;
        end
    end

    assign cfg_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign load_start_valid = load_start_valid_q;
    assign load_layer       = load_layer_q;
    assign step_valid       = step_valid_q;
    assign step_ts          = step_ts_q;
    assign step_layer       = step_layer_q;
    assign run_done         = run_done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_snn_run_ctrl.sv
// Directed bench for snn_run_ctrl; the watchdog scenario is built only with SNN_CTRL_TIMEOUT_EN.
module tb_snn_run_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_num_ts;
    logic [1:0] cfg_num_layers;
    logic       load_start_valid;
    logic       load_start_ready;
    logic [1:0] load_layer;
    logic       load_done;
    logic       step_valid;
    logic       step_ready;
    logic [3:0] step_ts;
    logic [1:0] step_layer;
    logic       step_done;
    logic       busy;
    logic       run_done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    // Event log entries: {kind(1=load,2=step), layer, ts}.
    logic [7:0] ev_q[$];
    logic [7:0] exp_q[$];

    snn_run_ctrl #(
        .TS_W          (4),
        .LAYER_W       (2),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_num_ts      (cfg_num_ts),
        .cfg_num_layers  (cfg_num_layers),
        .load_start_valid(load_start_valid),
        .load_start_ready(load_start_ready),
        .load_layer      (load_layer),
        .load_done       (load_done),
        .step_valid      (step_valid),
        .step_ready      (step_ready),
        .step_ts         (step_ts),
        .step_layer      (step_layer),
        .step_done       (step_done),
        .busy            (busy),
        .run_done        (run_done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag);
        check($sformatf("%s_len", tag), ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i),
                  (i < ev_q.size()) ? {24'd0, ev_q[i]} : 32'hdead, {24'd0, exp_q[i]});
        end
    endtask

    // Readies high; each done returns with one idle cycle after its handshake.
    task automatic run_auto(input logic [3:0] ts, input logic [1:0] ly, input bit mid_cfg,
                            input string tag);
        int  cyc;
        int  post;
        int  n_done;
        int  ld_cnt;
        int  sd_cnt;
        bit  hs_l;
        bit  hs_s;
        ev_q.delete();
        cyc    = 0;
        post   = -1;
        n_done = 0;
        ld_cnt = 0;
        sd_cnt = 0;
        cfg_valid        = 1'b1;
        cfg_num_ts       = ts;
        cfg_num_layers   = ly;
        load_start_ready = 1'b1;
        step_ready       = 1'b1;
        tick();
        check($sformatf("%s_accept_busy", tag), busy, 1);
        if (mid_cfg) begin
            cfg_num_ts     = 4'd7;
            cfg_num_layers = 2'd3;
        end else begin
            cfg_valid = 1'b0;
        end
        while (cyc < 400 && post != 0) begin
            hs_l = load_start_valid & load_start_ready;
            hs_s = step_valid & step_ready;
            if (hs_l) ev_q.push_back({2'd1, load_layer, 4'd0});
            if (hs_s) ev_q.push_back({2'd2, step_layer, step_ts});
            tick();
            cyc++;
            load_done = 1'b0;
            step_done = 1'b0;
            if (ld_cnt == 1) load_done = 1'b1;
            if (ld_cnt > 0) ld_cnt--;
            if (hs_l) ld_cnt = 1;
            if (sd_cnt == 1) step_done = 1'b1;
            if (sd_cnt > 0) sd_cnt--;
            if (hs_s) sd_cnt = 1;
            if (run_done) begin
                n_done++;
                cfg_valid = 1'b0;
                if (post < 0) post = 3;
            end
            if (post > 0) post--;
        end
        load_done = 1'b0;
        step_done = 1'b0;
        check($sformatf("%s_run_done_count", tag), n_done, 1);
        check($sformatf("%s_idle_after", tag), {cfg_ready, busy, err}, 3'b100);
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_valid        = 1'b0;
        cfg_num_ts       = '0;
        cfg_num_layers   = '0;
        load_start_ready = 1'b0;
        load_done        = 1'b0;
        step_ready       = 1'b0;
        step_done        = 1'b0;
        #12;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valids", {load_start_valid, step_valid, run_done, err}, 4'b0000);
        check("rst_payload", {load_layer, step_ts, step_layer}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1 layer x 1 ts, exact cycle timing.
        cfg_valid        = 1'b1;
        cfg_num_ts       = 4'd1;
        cfg_num_layers   = 2'd1;
        load_start_ready = 1'b1;
        step_ready       = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("t1_load_req", {load_start_valid, busy, cfg_ready}, 3'b110);
        check("t1_load_layer", load_layer, 0);
        tick();
        check("t1_load_valid_drop", load_start_valid, 0);
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("t1_step_req", {step_valid, step_layer, step_ts}, 7'b1_00_0000);
        tick();
        check("t1_step_valid_drop", step_valid, 0);
        tick();
        check("t1_no_early_done", run_done, 0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("t1_run_done_cyc6", {run_done, busy, cfg_ready}, 3'b110);
        tick();
        check("t1_back_idle", {run_done, busy, cfg_ready}, 3'b001);

        // 2 layers x 3 ts sequence.
        run_auto(4'd3, 2'd2, 1'b0, "t2");
        exp_q = '{8'h40, 8'h80, 8'h81, 8'h82, 8'h50, 8'h90, 8'h91, 8'h92};
        check_log("t2");

        // step_ready held low; stray and handshake-coincident step_done ignored.
        cfg_valid        = 1'b1;
        cfg_num_ts       = 4'd1;
        cfg_num_layers   = 2'd1;
        load_start_ready = 1'b1;
        step_ready       = 1'b0;
        tick();
        cfg_valid = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_done = (i == 2);
            tick();
            check($sformatf("t3_hold%0d", i), {step_valid, step_layer, step_ts}, 7'b1_00_0000);
        end
        step_ready = 1'b1;
        step_done  = 1'b1;
        tick();
        step_done = 1'b0;
        check("t3_step_taken", {step_valid, run_done}, 2'b00);
        tick();
        tick();
        check("t3_still_waiting", {busy, run_done}, 2'b10);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("t3_run_done", run_done, 1);
        tick();

        // num_ts=0 / num_layers=0 behave as 1; cfg held high mid-run is ignored.
        run_auto(4'd0, 2'd0, 1'b1, "t4");
        exp_q = '{8'h40, 8'h80};
        check_log("t4");

        // Asynchronous reset during STEP_WAIT of layer 1.
        cfg_valid      = 1'b1;
        cfg_num_ts     = 4'd1;
        cfg_num_layers = 2'd2;
        tick();
        cfg_valid = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("t5_load_l1", {load_start_valid, load_layer}, 3'b1_01);
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("t5_step_l1", {step_valid, step_layer, step_ts}, 7'b1_01_0000);
        tick();
        check("t5_in_wait", {step_valid, busy}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_state", {cfg_ready, busy}, 2'b10);
        check("t5_rst_outs", {load_start_valid, step_valid, run_done, err}, 4'b0000);
        check("t5_rst_payload", {load_layer, step_ts, step_layer}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_auto(4'd1, 2'd2, 1'b0, "t5r");
        exp_q = '{8'h40, 8'h80, 8'h50, 8'h90};
        check_log("t5r");

`ifdef SNN_CTRL_TIMEOUT_EN
        // Withheld load_done trips the 16-cycle watchdog.
        cfg_valid      = 1'b1;
        cfg_num_ts     = 4'd1;
        cfg_num_layers = 2'd1;
        tick();
        cfg_valid = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("t6_no_err_yet", {err, busy}, 2'b01);
        end
        check("t6_err", {err, run_done, cfg_ready, busy}, 4'b1010);
        tick();
        check("t6_err_sticky", err, 1);
        run_auto(4'd1, 2'd1, 1'b0, "t6r");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
